// File: rtl/luma_pkg.sv
// Shared types and constants for the RGB-to-luma pipeline: input formats,
// coefficient/sum widths, default coefficients and the per-stage payloads.
package luma_pkg;

    localparam int FMT_RGB565 = 0;
    localparam int FMT_RGB888 = 1;

    localparam int COEF_W = 8;
    localparam int SUM_W  = 18;

    localparam int DEFAULT_COEF_R = 77;
    localparam int DEFAULT_COEF_G = 150;
    localparam int DEFAULT_COEF_B = 29;

    // data holds expanded RGB888, the raw weighted sum or the final luma,
    // depending on which stage the beat sits in
    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic        eol;
    } beat_t;

    typedef struct packed {
        logic [COEF_W-1:0] r;
        logic [COEF_W-1:0] g;
        logic [COEF_W-1:0] b;
    } coef_set_t;

    typedef struct packed {
        coef_set_t coef;
        beat_t     beat;
    } s1_t;

endpackage

// File: rtl/rgb_to_luma_pipe_if.sv
// Pixel stream in, luma stream out, with valid/ready handshakes, frame
// sideband and the requested coefficient set.
interface rgb_to_luma_pipe_if #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]              in_pixel;
    logic                         in_sof;
    logic                         in_eol;
    logic                         in_valid;
    logic                         in_ready;
    logic [luma_pkg::COEF_W-1:0]  coef_r;
    logic [luma_pkg::COEF_W-1:0]  coef_g;
    logic [luma_pkg::COEF_W-1:0]  coef_b;
    logic [OUT_W-1:0]             out_luma;
    logic                         out_sof;
    logic                         out_eol;
    logic                         out_valid;
    logic                         out_ready;

    modport slave (
        input  in_pixel, in_sof, in_eol, in_valid, coef_r, coef_g, coef_b, out_ready,
        output in_ready, out_luma, out_sof, out_eol, out_valid
    );

    modport master (
        output in_pixel, in_sof, in_eol, in_valid, coef_r, coef_g, coef_b, out_ready,
        input  in_ready, out_luma, out_sof, out_eol, out_valid
    );
endinterface

// File: rtl/luma_pipe_stage.sv
// One stallable pipeline register: payload plus valid, loading whenever it is
// empty or its current contents are taken downstream in the same cycle.
module luma_pipe_stage #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         vld_q;
    logic [W-1:0] data_q;

    assign up_ready = !vld_q || dn_ready;
    assign dn_valid = vld_q;
    assign dn_data  = data_q;

    // payload only updates on a real load so a stalled output stays stable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            if (up_ready) vld_q <= up_valid;
            if (up_ready && up_valid) data_q <= up_data;
        end
    end

endmodule

// File: rtl/rgb_to_luma_pipe.sv
// Weighted RGB-to-luma converter: expand -> multiply/accumulate ->
// round/saturate, three stallable stages with sof/eol riding along.
module rgb_to_luma_pipe
    import luma_pkg::*;
#(
    parameter int IN_FMT     = FMT_RGB565,
    parameter int IN_W       = 24,
    parameter int OUT_W      = 8,
    parameter int DEF_COEF_R = DEFAULT_COEF_R,
    parameter int DEF_COEF_G = DEFAULT_COEF_G,
    parameter int DEF_COEF_B = DEFAULT_COEF_B
) (
    input logic               clk,
    input logic               reset_n,
    rgb_to_luma_pipe_if.slave bus
);

    function automatic logic [23:0] expand_rgb(input logic [23:0] pix);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = pix[15:11];
        g6 = pix[10:5];
        b5 = pix[4:0];
        if (IN_FMT == FMT_RGB888) expand_rgb = pix;
        else expand_rgb = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

    function automatic logic [OUT_W-1:0] round_sat(input logic [SUM_W-1:0] sum);
        logic [SUM_W:0] rounded;
        logic [SUM_W:0] scaled;
        rounded = {1'b0, sum} + ((SUM_W+1)'(1) << (15 - OUT_W));
        scaled  = rounded >> (16 - OUT_W);
        if (|scaled[SUM_W:OUT_W]) round_sat = {OUT_W{1'b1}};
        else round_sat = scaled[OUT_W-1:0];
    endfunction

    logic [31:0] pix_ext;
    coef_set_t   coef_act;
    coef_set_t   coef_req;
    coef_set_t   coef_eff;
    logic        accept;

    s1_t         s1_in;
    s1_t         s1_p1;
    logic        vld_p1;
    logic        rdy_p1;
    beat_t       s2_in;
    beat_t       s2_p2;
    logic        vld_p2;
    logic        rdy_p2;
    beat_t       s3_in;
    beat_t       s3_p3;

    logic [15:0]      prod_r_p1;
    logic [15:0]      prod_g_p1;
    logic [15:0]      prod_b_p1;
    logic [SUM_W-1:0] sum_p1;

    assign pix_ext  = 32'(bus.in_pixel);
    assign coef_req = {bus.coef_r, bus.coef_g, bus.coef_b};
    assign accept   = bus.in_valid && bus.in_ready;

    // an accepted SOF beat already uses the coefficients it brings in
    assign coef_eff = bus.in_sof ? coef_req : coef_act;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coef_act.r <= COEF_W'(DEF_COEF_R);
            coef_act.g <= COEF_W'(DEF_COEF_G);
            coef_act.b <= COEF_W'(DEF_COEF_B);
        end else if (accept && bus.in_sof) begin
            coef_act <= coef_req;
        end
    end

    // stage 1: channel expansion, coefficients captured per beat
    always_comb begin
        s1_in.coef      = coef_eff;
        s1_in.beat.data = expand_rgb(pix_ext[23:0]);
        s1_in.beat.sof  = bus.in_sof;
        s1_in.beat.eol  = bus.in_eol;
    end

    luma_pipe_stage #(.W($bits(s1_t))) u_stage1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .up_valid (bus.in_valid),
        .up_ready (bus.in_ready),
        .up_data  (s1_in),
        .dn_valid (vld_p1),
        .dn_ready (rdy_p1),
        .dn_data  (s1_p1)
    );

    // stage 2: full-precision weighted sum
    always_comb begin
        prod_r_p1  = s1_p1.beat.data[23:16] * s1_p1.coef.r;
        prod_g_p1  = s1_p1.beat.data[15:8]  * s1_p1.coef.g;
        prod_b_p1  = s1_p1.beat.data[7:0]   * s1_p1.coef.b;
        sum_p1     = SUM_W'(prod_r_p1) + SUM_W'(prod_g_p1) + SUM_W'(prod_b_p1);
        s2_in.data = 24'(sum_p1);
        s2_in.sof  = s1_p1.beat.sof;
        s2_in.eol  = s1_p1.beat.eol;
    end

    luma_pipe_stage #(.W($bits(beat_t))) u_stage2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .up_valid (vld_p1),
        .up_ready (rdy_p1),
        .up_data  (s2_in),
        .dn_valid (vld_p2),
        .dn_ready (rdy_p2),
        .dn_data  (s2_p2)
    );

    // stage 3: round to nearest and clamp to the output range
    always_comb begin
        s3_in.data = 24'(round_sat(s2_p2.data[SUM_W-1:0]));
        s3_in.sof  = s2_p2.sof;
        s3_in.eol  = s2_p2.eol;
    end

    luma_pipe_stage #(.W($bits(beat_t))) u_stage3 (
        .clk      (clk),
        .reset_n  (reset_n),
        .up_valid (vld_p2),
        .up_ready (rdy_p2),
        .up_data  (s3_in),
        .dn_valid (bus.out_valid),
        .dn_ready (bus.out_ready),
        .dn_data  (s3_p3)
    );

    assign bus.out_luma = s3_p3.data[OUT_W-1:0];
    assign bus.out_sof  = s3_p3.sof;
    assign bus.out_eol  = s3_p3.eol;

    logic unused_bits;
    assign unused_bits = ^{pix_ext[31:24], s2_p2.data[23:SUM_W], s3_p3.data[23:OUT_W]};

endmodule

// File: tb/tb_rgb_to_luma_pipe.sv
// Bench for rgb_to_luma_pipe: an RGB565/8-bit and an RGB888/10-bit instance
// checked against an arithmetic luma model, plus directed literal results.
module tb_rgb_to_luma_pipe;

    logic clk;
    logic reset_n;

    rgb_to_luma_pipe_if #(.IN_W(24), .OUT_W(8))  bus0 ();
    rgb_to_luma_pipe_if #(.IN_W(24), .OUT_W(10)) bus1 ();

    rgb_to_luma_pipe #(.IN_FMT(0), .IN_W(24), .OUT_W(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    rgb_to_luma_pipe #(.IN_FMT(1), .IN_W(24), .OUT_W(10)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] pix  [2];
    logic        sof  [2];
    logic        eol  [2];
    logic        vin  [2];
    logic [7:0]  cr   [2];
    logic [7:0]  cg   [2];
    logic [7:0]  cb   [2];
    logic        ordy [2];

    logic        m_inrdy [2];
    logic        m_ovld  [2];
    logic        m_osof  [2];
    logic        m_oeol  [2];
    logic [11:0] m_luma  [2];

    assign bus0.in_pixel = pix[0];  assign bus1.in_pixel = pix[1];
    assign bus0.in_sof   = sof[0];  assign bus1.in_sof   = sof[1];
    assign bus0.in_eol   = eol[0];  assign bus1.in_eol   = eol[1];
    assign bus0.in_valid = vin[0];  assign bus1.in_valid = vin[1];
    assign bus0.coef_r   = cr[0];   assign bus1.coef_r   = cr[1];
    assign bus0.coef_g   = cg[0];   assign bus1.coef_g   = cg[1];
    assign bus0.coef_b   = cb[0];   assign bus1.coef_b   = cb[1];
    assign bus0.out_ready = ordy[0]; assign bus1.out_ready = ordy[1];

    assign m_inrdy[0] = bus0.in_ready;  assign m_inrdy[1] = bus1.in_ready;
    assign m_ovld[0]  = bus0.out_valid; assign m_ovld[1]  = bus1.out_valid;
    assign m_osof[0]  = bus0.out_sof;   assign m_osof[1]  = bus1.out_sof;
    assign m_oeol[0]  = bus0.out_eol;   assign m_oeol[1]  = bus1.out_eol;
    assign m_luma[0]  = 12'(bus0.out_luma);
    assign m_luma[1]  = 12'(bus1.out_luma);

    typedef struct {
        int luma;
        bit sof;
        bit eol;
        int cyc;
    } exp_t;

    exp_t q0 [$];
    exp_t q1 [$];
    int   cap0 [$];
    int   cap1 [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit lat_chk  = 0;
    int ar [2];
    int ag [2];
    int ab [2];
    int acc_cnt  [2];
    int emit_cnt [2];
    bit hold      [2];
    int hold_luma [2];
    int hold_side [2];

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Luma as a fraction of full scale: Y = sum/65536 * 2^W, rounded half up.
    function automatic int model_luma(input int d, input int p, input int wr, input int wg, input int wb);
        int r, g, b, c, sum, y, w;
        if (d == 0) begin
            c = (p >> 11) & 31; r = (c << 3) | (c >> 2);
            c = (p >> 5) & 63;  g = (c << 2) | (c >> 4);
            c = p & 31;         b = (c << 3) | (c >> 2);
            w = 8;
        end else begin
            r = (p >> 16) & 255; g = (p >> 8) & 255; b = p & 255;
            w = 10;
        end
        sum = r * wr + g * wg + b * wb;
        y = ((sum << w) + 32768) >> 16;
        if (y > (1 << w) - 1) y = (1 << w) - 1;
        return y;
    endfunction

    task automatic mon(input int d);
        exp_t e;
        int   qs;
        if (vin[d] && m_inrdy[d]) begin
            if (sof[d]) begin ar[d] = int'(cr[d]); ag[d] = int'(cg[d]); ab[d] = int'(cb[d]); end
            e.luma = model_luma(d, int'(pix[d]), ar[d], ag[d], ab[d]);
            e.sof  = sof[d];
            e.eol  = eol[d];
            e.cyc  = cyc;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            acc_cnt[d]++;
        end
        if (hold[d]) begin
            chk("stall_valid", int'(m_ovld[d]), 1);
            chk("stall_luma", int'(m_luma[d]), hold_luma[d]);
            chk("stall_side", int'({m_osof[d], m_oeol[d]}), hold_side[d]);
        end
        if (m_ovld[d] && ordy[d]) begin
            qs = (d == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                chk("output_without_input", qs, 1);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk(d == 0 ? "luma565" : "luma888", int'(m_luma[d]), e.luma);
                chk("out_sof", int'(m_osof[d]), int'(e.sof));
                chk("out_eol", int'(m_oeol[d]), int'(e.eol));
                if (lat_chk) chk("latency", cyc - e.cyc, 3);
            end
            if (d == 0) cap0.push_back(int'(m_luma[0])); else cap1.push_back(int'(m_luma[1]));
            emit_cnt[d]++;
        end
        hold[d]      = m_ovld[d] && !ordy[d];
        hold_luma[d] = int'(m_luma[d]);
        hold_side[d] = int'({m_osof[d], m_oeol[d]});
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            q0.delete();
            q1.delete();
            for (int d = 0; d < 2; d++) begin
                ar[d] = 77; ag[d] = 150; ab[d] = 29;
                hold[d] = 0;
            end
        end else begin
            mon(0);
            mon(1);
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input int p, input bit s, input bit e);
        int n;
        n = 0;
        pix[d] = 24'(p); sof[d] = s; eol[d] = e; vin[d] = 1'b1;
        @(negedge clk);
        while (!m_inrdy[d] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("send_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cap(input int d, input int idx, input int val);
        int sz;
        sz = (d == 0) ? cap0.size() : cap1.size();
        if (idx >= sz) chk("capture_missing", sz, idx + 1);
        else chk(d == 0 ? "cap565" : "cap888", (d == 0) ? cap0[idx] : cap1[idx], val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pix[d] = '0; sof[d] = 0; eol[d] = 0; vin[d] = 0;
            cr[d] = 8'd77; cg[d] = 8'd150; cb[d] = 8'd29; ordy[d] = 1;
            acc_cnt[d] = 0; emit_cnt[d] = 0;
        end
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", int'(m_ovld[d]), 0);
            chk("rst_out_luma", int'(m_luma[d]), 0);
            chk("rst_out_sof", int'(m_osof[d]), 0);
            chk("rst_out_eol", int'(m_oeol[d]), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst0", int'(m_inrdy[0]), 1);
        chk("in_ready_after_rst1", int'(m_inrdy[1]), 1);
        step();

        // Defaults, back-to-back, exact latency
        lat_chk = 1;
        cap0.delete(); cap1.delete();
        send(0, 'hFFFF, 1, 0);
        send(0, 'h0000, 0, 0);
        send(0, 'hF800, 0, 0);
        send(0, 'h07E0, 0, 0);
        send(0, 'hAB001F, 0, 1);
        vin[0] = 0;
        send(1, 'hFFFFFF, 1, 0);
        send(1, 'h808080, 0, 1);
        vin[1] = 0;
        repeat (6) step();
        lat_chk = 0;
        expect_cap(0, 0, 255); expect_cap(0, 1, 0); expect_cap(0, 2, 77);
        expect_cap(0, 3, 149); expect_cap(0, 4, 29);
        expect_cap(1, 0, 1020); expect_cap(1, 1, 512);

        // Saturation, then mid-frame coefficient change ignored, then SOF latch
        cap0.delete();
        cr[0] = 255; cg[0] = 255; cb[0] = 255;
        send(0, 'hFFFF, 1, 0);
        send(0, 'h0000, 0, 0);
        cr[0] = 0; cg[0] = 255; cb[0] = 0;
        send(0, 'hF800, 0, 1);
        send(0, 'h07E0, 1, 0);
        send(0, 'hF800, 0, 1);
        vin[0] = 0;
        repeat (6) step();
        expect_cap(0, 0, 255); expect_cap(0, 1, 0); expect_cap(0, 2, 254);
        expect_cap(0, 3, 254); expect_cap(0, 4, 0);

        // Backpressure: 10 pixels, out_ready low for 5 cycles mid-stream
        cap0.delete();
        cr[0] = 77; cg[0] = 150; cb[0] = 29;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(0, int'($urandom_range(0, 'hFFFF)), i == 0, (i == 4) || (i == 9));
                vin[0] = 0;
            end
            begin
                repeat (4) step();
                ordy[0] = 0;
                repeat (2) step();
                @(negedge clk);
                chk("bp_in_ready_low", int'(m_inrdy[0]), 0);
                chk("bp_beats_held", acc_cnt[0] - emit_cnt[0], 3);
                repeat (3) step();
                ordy[0] = 1;
            end
        join
        repeat (6) step();
        chk("bp_count", cap0.size(), 10);

        // Reset with three beats in flight
        cap0.delete();
        ordy[0] = 0;
        cr[0] = 0; cg[0] = 255; cb[0] = 0;
        send(0, 'h07E0, 1, 0);
        send(0, 'hFFFF, 0, 0);
        send(0, 'hF800, 0, 1);
        vin[0] = 0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(m_ovld[0]), 0);
        chk("midrst_out_luma", int'(m_luma[0]), 0);
        step(); step();
        reset_n = 1'b1;
        ordy[0] = 1;
        repeat (5) step();
        chk("no_stale_after_rst", cap0.size(), 0);
        send(0, 'hF800, 0, 0);
        send(0, 'h07E0, 0, 1);
        vin[0] = 0;
        repeat (6) step();
        expect_cap(0, 0, 77);
        expect_cap(0, 1, 149);

        // Randomized traffic on both builds
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 2; d++) begin
                vin[d]  = ($urandom_range(0, 3) != 0);
                pix[d]  = 24'($urandom);
                sof[d]  = ($urandom_range(0, 7) == 0);
                eol[d]  = ($urandom_range(0, 7) == 0);
                cr[d]   = 8'($urandom_range(0, 255));
                cg[d]   = 8'($urandom_range(0, 255));
                cb[d]   = 8'($urandom_range(0, 255));
                ordy[d] = ($urandom_range(0, 9) < 7);
            end
            step();
        end
        vin[0] = 0; vin[1] = 0; ordy[0] = 1; ordy[1] = 1;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 100) begin
            n++;
            step();
        end
        chk("drain_empty", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
